// File: rtl/fp_mult_share_arbiter.sv
// Round-robin sharing of one enable/done floating-point multiplier among N_REQ requesters.
// Optional abort of a stalled operation is built when ARB_TIMEOUT_EN is defined.
module fp_mult_share_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] dataa_bus,
    input  logic [32*N_REQ-1:0] datab_bus,
    output logic [N_REQ-1:0]    ack,
    output logic [31:0]         result,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic                err,
    output logic                unit_enable,
    output logic [31:0]         unit_dataa,
    output logic [31:0]         unit_datab,
    input  logic [31:0]         unit_result,
    input  logic                unit_done
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int          OPW  = 32'sd32;
    localparam int          PW   = (N_REQ > 32'sd1) ? $clog2(N_REQ) : 32'sd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         state_r;
    logic [IDW-1:0] rr_ptr_r;
    logic [IDW-1:0] sel_idx_s;
    logic           sel_valid_s;
    logic [PW-1:0]  sel_pw_s;
    logic           tmo_hit_s;
    logic [31:0]    op_a_s [N_REQ];
    logic [31:0]    op_b_s [N_REQ];

    // First requesting index at or after ptr, wrapping at N_REQ; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                             input logic [IDW-1:0]   ptr);
        logic [IDW:0] pick;
        int           idx;
        pick = {(IDW+1){1'b0}};
        for (int k = N_REQ - 32'sd1; k >= 32'sd0; k--) begin
            idx  = (int'(ptr) + k) % N_REQ;
            pick = req_v[PW'(idx)] ? {1'b1, IDW'(idx)} : pick;
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        return IDW'((int'(id) + 32'sd1) % N_REQ);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a_s[g] = dataa_bus[OPW*g +: OPW];
        assign op_b_s[g] = datab_bus[OPW*g +: OPW];
    end

    // Candidate for the next grant, searched round-robin from rr_ptr_r
    always_comb begin
        {sel_valid_s, sel_idx_s} = rr_pick(req, rr_ptr_r);
        sel_pw_s                 = PW'(sel_idx_s);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 32'sd1);
    logic [TW-1:0] tmo_cnt_r;

    // Counts BUSY cycles spent waiting for done; cleared outside BUSY
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_BUSY && !unit_done) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 32'sd1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Grant / hold / release sequencing with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            ack         <= '0;
            result      <= 32'd0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            unit_enable <= 1'b0;
            unit_dataa  <= 32'd0;
            unit_datab  <= 32'd0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // a done left high by the unit blocks new grants until it clears
                    if (sel_valid_s && !unit_done) begin
                        unit_dataa  <= op_a_s[sel_pw_s];
                        unit_datab  <= op_b_s[sel_pw_s];
                        grant_id    <= sel_idx_s;
                        unit_enable <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (unit_done) begin
                        result      <= unit_result;
                        ack         <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                        unit_enable <= 1'b0;
                        rr_ptr_r    <= rr_next(grant_id);
                        state_r     <= ST_RELEASE;
                    end else if (tmo_hit_s) begin
                        result      <= QNAN;
                        ack         <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                        err         <= 1'b1;
                        unit_enable <= 1'b0;
                        rr_ptr_r    <= rr_next(grant_id);
                        state_r     <= ST_RELEASE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_RELEASE: begin
                    if (!unit_done) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                default: begin
                    unit_enable <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_share_arbiter.sv
// Bench for fp_mult_share_arbiter: behavioural latency-5 multiplier, directed scenarios,
// then randomized requesters checked against a round-robin reference model.
module tb_fp_mult_share_arbiter;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam int TMO   = 40;
    localparam int LAT   = 5;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] dataa_bus;
    logic [32*N_REQ-1:0] datab_bus;
    logic [N_REQ-1:0]    ack;
    logic [31:0]         result;
    logic [IDW-1:0]      grant_id;
    logic                busy;
    logic                err;
    logic                unit_enable;
    logic [31:0]         unit_dataa;
    logic [31:0]         unit_datab;
    logic [31:0]         unit_result;
    logic                unit_done;

    always #5 clk = ~clk;

    fp_mult_share_arbiter #(
        .N_REQ(N_REQ), .IDW(IDW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .dataa_bus(dataa_bus), .datab_bus(datab_bus),
        .ack(ack), .result(result), .grant_id(grant_id), .busy(busy), .err(err),
        .unit_enable(unit_enable), .unit_dataa(unit_dataa), .unit_datab(unit_datab),
        .unit_result(unit_result), .unit_done(unit_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact single-precision product via double arithmetic (operands kept exactly representable)
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        real         rp;
        da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        rp = $bitstoreal(da) * $bitstoreal(db);
        dp = $realtobits(rp);
        return {dp[63], 8'(dp[62:52] - 11'd896), dp[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        logic [7:0] m;
        e = 8'(120 + $urandom_range(14, 0));
        m = 8'($urandom);
        return {1'($urandom), e, m, 15'd0};
    endfunction

    // Behavioural multiplier: done rises LAT cycles after enable, held until enable drops
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic        stuck    = 1'b0;
    logic        spurious = 1'b0;

    always @(posedge clk) begin
        if (!unit_enable) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_done && !stuck) begin
            if (m_cnt == LAT - 1) begin
                m_done <= 1'b1;
                m_res  <= fmul(unit_dataa, unit_datab);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign unit_done   = m_done | spurious;
    assign unit_result = m_res;

    // What the DUT saw at each rising edge
    logic [N_REQ-1:0]    req_e;
    logic [32*N_REQ-1:0] a_e, b_e;
    logic                done_e, rst_e;
    always @(posedge clk) begin
        req_e  <= req;
        a_e    <= dataa_bus;
        b_e    <= datab_bus;
        done_e <= unit_done;
        rst_e  <= reset_n;
    end

    // Reference model state
    int          ptr_m = 0, pend = -1, grant_cyc = 0, cyc = 0, exp_idx = 0;
    int          idle_seen = 1, ack_total = 0;
    int          serve_cnt [N_REQ];
    int          ack_q [$];
    logic [31:0] exp_res = 32'd0, last_res = 32'd0;
    logic        exp_err = 1'b0, en_prev = 1'b0;

    initial begin
        for (int i = 0; i < N_REQ; i++) serve_cnt[i] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_e) begin
                check_eq("rst_ctrl", 32'({ack, busy, err, unit_enable, grant_id}), 32'd0);
                check_eq("rst_result", result, 32'd0);
                check_eq("rst_ops", unit_dataa | unit_datab, 32'd0);
                ptr_m = 0; pend = -1; last_res = 32'd0; idle_seen = 1;
            end else begin
                if (unit_enable && !en_prev) begin
                    exp_idx = -1;
                    for (int k = N_REQ - 1; k >= 0; k--)
                        if (req_e[(ptr_m + k) % N_REQ]) exp_idx = (ptr_m + k) % N_REQ;
                    check_eq("grant_done_low", 32'(done_e), 32'd0);
                    check_eq("grant_id", 32'(grant_id), 32'(exp_idx));
                    check_eq("dead_cycle", 32'(idle_seen), 32'd1);
                    check_eq("held_result", result, last_res);
                    if (exp_idx < 0) exp_idx = int'(grant_id);
                    check_eq("grant_opa", unit_dataa, a_e[32*exp_idx +: 32]);
                    check_eq("grant_opb", unit_datab, b_e[32*exp_idx +: 32]);
                    pend      = exp_idx;
                    grant_cyc = cyc;
                    exp_err   = stuck;
                    exp_res   = stuck ? QNAN : fmul(a_e[32*exp_idx +: 32], b_e[32*exp_idx +: 32]);
                    idle_seen = 0;
                end else if (!busy) begin
                    idle_seen = 1;
                end
                if (ack != '0) begin
                    if (pend < 0) begin
                        check_eq("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        check_eq("ack_onehot", 32'(ack), 32'd1 << pend);
                        check_eq("ack_result", result, exp_res);
                        check_eq("ack_err", 32'(err), 32'(exp_err));
                        check_eq("ack_latency", 32'(cyc - grant_cyc), exp_err ? 32'(TMO) : 32'(LAT + 1));
                        check_eq("ack_busy", 32'(busy), 32'd1);
                        ptr_m    = (pend + 1) % N_REQ;
                        last_res = exp_res;
                        ack_total++;
                        serve_cnt[pend]++;
                        ack_q.push_back(pend);
                        pend = -1;
                    end
                end else if (pend >= 0 && cyc - grant_cyc > TMO + 20) begin
                    check_eq("ack_watchdog", 32'(cyc - grant_cyc), 32'(LAT + 1));
                    pend = -1;
                end
            end
            en_prev = unit_enable;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int t = 0;
        while (ack_total < target && t < budget) begin
            tick();
            t++;
        end
        check_eq("ack_wait", 32'(ack_total), 32'(target));
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        dataa_bus[32*i +: 32] = a;
        datab_bus[32*i +: 32] = b;
    endtask

    function automatic int q_at(input int idx);
        return (idx >= 0 && idx < ack_q.size()) ? ack_q[idx] : -1;
    endfunction

    int base, qbase, t;
    int snap [N_REQ];

    initial begin
        reset_n = 1'b0; req = '0; dataa_bus = '0; datab_bus = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // single request: 0.5 * 3.0
        set_op(0, 32'h3F00_0000, 32'h4040_0000);
        req[0] = 1'b1;
        base = ack_total;
        wait_acks(base + 1, 40);
        check_eq("t1_result", result, 32'h3FC0_0000);
        check_eq("t1_idx", 32'(q_at(ack_q.size() - 1)), 32'd0);
        req[0] = 1'b0;
        tick(4);

        // two simultaneous requests, 2.0 * 2.0 each
        set_op(1, 32'h4000_0000, 32'h4000_0000);
        set_op(2, 32'h4000_0000, 32'h4000_0000);
        req[1] = 1'b1; req[2] = 1'b1;
        base = ack_total;
        wait_acks(base + 1, 40);
        check_eq("t2_first_idx", 32'(q_at(ack_q.size() - 1)), 32'd1);
        check_eq("t2_first_res", result, 32'h4080_0000);
        req[1] = 1'b0;
        wait_acks(base + 2, 40);
        check_eq("t2_second_idx", 32'(q_at(ack_q.size() - 1)), 32'd2);
        check_eq("t2_second_res", result, 32'h4080_0000);
        req[2] = 1'b0;
        tick(4);

        // all requesters held high for 12 operations from rr_ptr=0
        reset_n = 1'b0; tick(1); reset_n = 1'b1; tick(2);
        for (int i = 0; i < N_REQ; i++) begin
            set_op(i, rand_fp(), rand_fp());
            snap[i] = serve_cnt[i];
        end
        qbase = ack_q.size();
        base  = ack_total;
        req   = '1;
        wait_acks(base + 12, 200);
        req = '0;
        for (int i = 0; i < N_REQ; i++)
            check_eq("t3_serve_cnt", 32'(serve_cnt[i] - snap[i]), 32'd3);
        for (int k = 0; k < 12; k++)
            check_eq("t3_order", 32'(q_at(qbase + k)), 32'(k % N_REQ));
        tick(6);

        // reset in the middle of an operation aborts it; rr restarts at 0
        set_op(3, rand_fp(), rand_fp());
        req[3] = 1'b1;
        t = 0;
        while (!unit_enable && t < 20) begin tick(); t++; end
        check_eq("t4_granted", 32'(unit_enable), 32'd1);
        tick(2);
        base    = ack_total;
        reset_n = 1'b0;
        set_op(1, rand_fp(), rand_fp());
        req[1] = 1'b1;
        tick(1);
        reset_n = 1'b1;
        check_eq("t4_enable_off", 32'(unit_enable), 32'd0);
        wait_acks(base + 1, 60);
        check_eq("t4_first_idx", 32'(q_at(ack_q.size() - 1)), 32'd1);
        req[1] = 1'b0;
        wait_acks(base + 2, 60);
        check_eq("t4_second_idx", 32'(q_at(ack_q.size() - 1)), 32'd3);
        req[3] = 1'b0;
        tick(4);

        // operands changed and req dropped after grant: 3.0 * 5.0 still produced
        set_op(0, 32'h4040_0000, 32'h40A0_0000);
        req[0] = 1'b1;
        base = ack_total;
        t = 0;
        while (!unit_enable && t < 20) begin tick(); t++; end
        tick(1);
        req[0] = 1'b0;
        dataa_bus[31:0] = 32'h4100_0000;
        wait_acks(base + 1, 40);
        check_eq("t5_result", result, 32'h4170_0000);
        tick(4);

        // done high while idle blocks granting
        spurious = 1'b1;
        tick(1);
        set_op(2, rand_fp(), rand_fp());
        req[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t6_hold_idle", 32'(unit_enable), 32'd0);
        end
        spurious = 1'b0;
        base = ack_total;
        wait_acks(base + 1, 40);
        check_eq("t6_idx", 32'(q_at(ack_q.size() - 1)), 32'd2);
        req[2] = 1'b0;
        tick(4);

        // randomized requesters
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1, 0) == 1) set_op(i, rand_fp(), rand_fp());
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        set_op(i, rand_fp(), rand_fp());
                        req[i] = 1'b1;
                    end
                end else if (busy && grant_id == IDW'(i) && $urandom_range(7, 0) == 0) begin
                    set_op(i, rand_fp(), rand_fp());
                    req[i] = 1'($urandom);
                end
            end
            tick();
        end
        req = '0;
        t = 0;
        while (busy && t < 100) begin tick(); t++; end
        check_eq("drain_idle", 32'(busy), 32'd0);
        tick(2);

`ifdef ARB_TIMEOUT_EN
        // stalled unit: abort with qNaN and err, then a normal operation (2.0 * 3.0)
        stuck = 1'b1;
        set_op(1, rand_fp(), rand_fp());
        req[1] = 1'b1;
        base = ack_total;
        wait_acks(base + 1, TMO + 30);
        check_eq("tmo_result", result, QNAN);
        req[1] = 1'b0;
        tick(1);
        stuck = 1'b0;
        tick(3);
        set_op(1, 32'h4000_0000, 32'h4040_0000);
        req[1] = 1'b1;
        wait_acks(base + 2, 40);
        check_eq("tmo_next_result", result, 32'h40C0_0000);
        req[1] = 1'b0;
        tick(4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
